// File: rtl/sd_pkg.sv
// Shared constants and helpers for the sigma-delta ADC receive path.
package sd_pkg;

   localparam int unsigned DECIM_LOG2_MIN = 4;
   localparam int unsigned DECIM_LOG2_MAX = 12;
   localparam int unsigned OUT_W_MIN      = 1;

   // Warm-up tracking: the first comb output after reset is built from a
   // partially filled filter and is never reported.
   typedef enum logic {
      WARM_COLD = 1'b0,
      WARM_RUN  = 1'b1
   } warm_e;

   // Integrator/comb word width for a sinc2 filter of ratio 2^decim_log2:
   // full-scale output is R^2 = 2^(2*decim_log2), plus one bit to hold it.
   function automatic int unsigned cic_width(input int unsigned decim_log2);
      return 2 * decim_log2 + 1;
   endfunction

   // Clamp an unsigned value to the largest out_w-bit code.
   function automatic logic [31:0] sat_unsigned(input logic [31:0] value,
                                                input int unsigned out_w);
      logic [31:0] max_val;
      max_val = (32'd1 << out_w) - 32'd1;
      return (value > max_val) ? max_val : value;
   endfunction

endpackage

// File: rtl/sd_cic2_decim.sv
// Second-order CIC decimator: 1-bit modulator stream in, unsigned PCM out.
//
// state     | meaning
// WARM_COLD | no comb output yet since reset; the first one is discarded
// WARM_RUN  | every comb output is reported with sample_valid
module sd_cic2_decim
   import sd_pkg::*;
#(
   parameter int unsigned DECIM_LOG2 = 8,
   parameter int unsigned OUT_W      = 8
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             bit_en,
   input  logic             bit_in,
   output logic [OUT_W-1:0] sample,
   output logic             sample_valid
);

   localparam int unsigned W     = cic_width(DECIM_LOG2);
   localparam int unsigned SHIFT = W - 1 - OUT_W;
   localparam logic [DECIM_LOG2-1:0] CNT_ONE = 1;

   logic [W-1:0]          int1;
   logic [W-1:0]          int2;
   logic [W-1:0]          xd;
   logic [W-1:0]          c1d;
   logic [W-1:0]          c1;
   logic [W-1:0]          y;
   logic [W-1:0]          y_reg;
   logic                  y_valid;
   logic [DECIM_LOG2-1:0] dec_cnt;
   logic                  strobe;
   logic                  report;
   warm_e                 state;
   warm_e                 state_nxt;

   // Strobe on the last bit of each decimation period.
   assign strobe = bit_en && (dec_cnt == '1);
   // Arithmetic is modulo 2^W on purpose; wrap cancels in the comb.
   assign c1     = int2 - xd;
   assign y      = c1 - c1d;

   // Integrators and decimation counter advance only at the bit rate.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         int1    <= '0;
         int2    <= '0;
         dec_cnt <= '0;
      end else if (bit_en) begin
         int1    <= int1 + {{(W-1){1'b0}}, bit_in};
         int2    <= int2 + int1;
         dec_cnt <= dec_cnt + CNT_ONE;
      end
   end

   // Warm-up state register.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state <= WARM_COLD;
      end else begin
         state <= state_nxt;
      end
   end

   // Warm-up next state and report decision for the current strobe.
   always_comb begin
      state_nxt = state;
      report    = 1'b0;
      case (state)
         WARM_COLD: if (strobe) state_nxt = WARM_RUN;
         WARM_RUN:  report = strobe;
         default:   state_nxt = WARM_COLD;
      endcase
   end

   // Comb stage: capture Int2 and update the delay registers at the strobe.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         xd      <= '0;
         c1d     <= '0;
         y_reg   <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= strobe && report;
         if (strobe) begin
            xd    <= int2;
            c1d   <= c1;
            y_reg <= y;
         end
      end
   end

   // Output stage: scale, clamp full scale, and pulse valid one cycle later.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         sample       <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= y_valid;
         if (y_valid) begin
            sample <= OUT_W'(sat_unsigned(32'(y_reg >> SHIFT), OUT_W));
         end
      end
   end

endmodule

// File: rtl/sigma_delta_adc.sv
// Sigma-delta ADC front end: comparator synchronizer, feedback bit register
// driving the external RC integrator, and the sinc2 decimator.
module sigma_delta_adc
   import sd_pkg::*;
#(
   parameter int unsigned DECIM_LOG2 = 8,
   parameter int unsigned OUT_W      = 8
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             ClkEn,
   input  logic             CompIn,
   output logic             FbOut,
   output logic [OUT_W-1:0] Sample,
   output logic             SampleValid
);

   logic [1:0] sync_q;

   // Two-flop synchronizer for the asynchronous comparator; runs every Clk.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], CompIn};
      end
   end

   // Modulator bit: sampled at the bit rate, held in between.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         FbOut <= 1'b0;
      end else if (ClkEn) begin
         FbOut <= sync_q[1];
      end
   end

   sd_cic2_decim #(
      .DECIM_LOG2 (DECIM_LOG2),
      .OUT_W      (OUT_W)
   ) u_decim (
      .clk_sys      (Clk),
      .rst_b        (nReset),
      .bit_en       (ClkEn),
      .bit_in       (FbOut),
      .sample       (Sample),
      .sample_valid (SampleValid)
   );

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Scoreboard bench for sigma_delta_adc with DECIM_LOG2=8, OUT_W=8.
module tb_sigma_delta_adc;

   localparam int R = 256;

   logic       Clk    = 1'b0;
   logic       nReset = 1'b0;
   logic       ClkEn  = 1'b0;
   logic       CompIn = 1'b0;
   logic       FbOut;
   logic [7:0] Sample;
   logic       SampleValid;

   typedef struct packed {
      logic       chk;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int compared      = 0;
   int mismatched    = 0;
   int cyc           = 0;
   int rel_cyc       = 0;
   int first_lat     = -1;
   bit first_pending = 1'b0;
   int valid_cnt     = 0;
   int last_valid    = 0;
   int last_interval = 0;
   int pat_k         = 0;
   int pat_idx       = 0;
   logic prev_fb     = 1'b0;
   logic prev_rst    = 1'b0;

   always #5 Clk = ~Clk;

   sigma_delta_adc #(
      .DECIM_LOG2 (8),
      .OUT_W      (8)
   ) dut (
      .Clk         (Clk),
      .nReset      (nReset),
      .ClkEn       (ClkEn),
      .CompIn      (CompIn),
      .FbOut       (FbOut),
      .Sample      (Sample),
      .SampleValid (SampleValid)
   );

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge Clk) begin
      cyc++;
      #1;
      if (nReset && prev_rst && (FbOut !== prev_fb)) begin
         compared++;
         if (ClkEn !== 1'b1) begin
            mismatched++;
            $display("FAIL fb_only_on_clken: FbOut changed with ClkEn=%b at cycle %0d", ClkEn, cyc);
         end
      end
      prev_fb  = FbOut;
      prev_rst = nReset;
      if (SampleValid === 1'b1) begin
         valid_cnt++;
         last_interval = cyc - last_valid;
         last_valid    = cyc;
         if (first_pending) begin
            first_lat     = cyc - rel_cyc;
            first_pending = 1'b0;
         end
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_valid: Sample=%0d at cycle %0d with nothing expected", Sample, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.chk) begin
               compared++;
               if (Sample !== mon_e.val) begin
                  mismatched++;
                  $display("FAIL sample: got %0d expected %0d at cycle %0d", Sample, mon_e.val, cyc);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One Clk of stimulus; the pattern bit advances only on enabled cycles.
   task automatic drive_cycle(input logic [7:0] pat, input int plen, input int en_div, input bit glitch);
      logic en;
      @(negedge Clk);
      en    = ((pat_k % en_div) == 0);
      ClkEn = en;
      if (en) begin
         CompIn  = pat[pat_idx];
         pat_idx = (pat_idx + 1) % plen;
      end
      if (glitch && ((pat_k % 37) == 5)) begin
         #1 CompIn = ~CompIn;
         #2 CompIn = ~CompIn;
      end
      pat_k++;
   endtask

   // Queue expectations, run the pattern until they are consumed, then
   // optionally measure the spacing of the next SampleValid.
   task automatic run_pattern(input logic [7:0] pat, input int plen, input int en_div,
                              input int n_skip, input int n_chk, input logic [7:0] expv,
                              input int exp_period, input bit glitch);
      int k;
      int budget;
      int start_vc;
      pat_idx = 0;
      for (int i = 0; i < n_skip; i++) sb.push_back('{chk: 1'b0, val: 8'h00});
      for (int i = 0; i < n_chk; i++)  sb.push_back('{chk: 1'b1, val: expv});
      budget = (n_skip + n_chk + 2) * R * en_div + 64;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         drive_cycle(pat, plen, en_div, glitch);
         k++;
      end
      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL timeout_samples: %0d expected samples never arrived", sb.size());
         sb.delete();
      end
      if (exp_period != 0) begin
         sb.push_back('{chk: 1'b0, val: 8'h00});
         start_vc = valid_cnt;
         k = 0;
         while (valid_cnt == start_vc && k < 2 * R * en_div) begin
            drive_cycle(pat, plen, en_div, glitch);
            k++;
         end
         if (valid_cnt == start_vc) begin
            compared++;
            mismatched++;
            $display("FAIL timeout_period: no SampleValid within %0d cycles", k);
            sb.delete();
         end else begin
            check("valid_period", last_interval, exp_period);
         end
      end
   endtask

   // Asynchronous reset taken between edges, outputs checked before any edge.
   task automatic reset_and_release(input logic comp);
      @(negedge Clk);
      #3 nReset = 1'b0;
      sb.delete();
      first_pending = 1'b0;
      #1;
      check("rst_fbout", FbOut, 0);
      check("rst_sample", Sample, 0);
      check("rst_valid", SampleValid, 0);
      repeat (3) @(negedge Clk);
      ClkEn     = 1'b1;
      CompIn    = comp;
      first_lat = -1;
      nReset    = 1'b1;
      rel_cyc   = cyc;
      first_pending = 1'b1;
      pat_k     = 1;
   endtask

   initial begin
      // All zeros from reset: silent warm-up, then zeros every R cycles.
      reset_and_release(1'b0);
      run_pattern(8'b0000_0000, 1, 1, 0, 3, 8'd0, R, 1'b0);
      check("first_latency_zero", first_lat, 2 * R + 1);

      // All ones from reset: full scale clamps to 255.
      reset_and_release(1'b1);
      run_pattern(8'b0000_0001, 1, 1, 0, 3, 8'd255, 0, 1'b0);
      check("first_latency_ones", first_lat, 2 * R + 1);

      // 50% density every Clk.
      run_pattern(8'b0000_0001, 2, 1, 4, 3, 8'd128, R, 1'b0);

      // ClkEn one cycle in four, 25% density.
      run_pattern(8'b0000_0001, 4, 4, 4, 3, 8'd64, 4 * R, 1'b0);

      // Varying density; Int2 wraps many times along the way.
      run_pattern(8'b0000_0111, 4, 1, 4, 2, 8'd192, 0, 1'b0);
      run_pattern(8'b0000_0001, 8, 1, 4, 2, 8'd32, 0, 1'b0);
      run_pattern(8'b0111_1111, 8, 1, 4, 2, 8'd224, 0, 1'b0);

      // Reset in the middle of a period, then zeros with sub-cycle glitches.
      for (int i = 0; i < 100; i++) drive_cycle(8'b0111_1111, 8, 1, 1'b0);
      reset_and_release(1'b0);
      run_pattern(8'b0000_0000, 1, 1, 0, 2, 8'd0, 0, 1'b1);
      check("first_latency_rerst", first_lat, 2 * R + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1, "watchdog");
   end

endmodule
